// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/multdiv_step.sv
// One combinational iteration: shift-add for MULT, restoring shift-subtract for DIV.
module multdiv_step
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               op,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0] hi_sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;
    logic           fits;

    // The remainder stays below 2*divisor, so a WIDTH+1 bit difference keeps its sign exact.
    always_comb begin
        hi_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        rem_sh = acc[2*WIDTH-1:WIDTH-1];
        diff   = rem_sh - {1'b0, operand};
        fits   = ~diff[WIDTH];
        if (op == OP_MULT) begin
            acc_next = {hi_sum, acc[WIDTH-1:1]};
        end else begin
            acc_next = {(fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], fits};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide feeding the HI/LO pair.
// Optional MULTDIV_DIV0_EN: a zero divisor skips straight to DONE and pulses div_zero.
module mult_div_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic [2*WIDTH-1:0] result,
    output logic               result_wr,
    output logic               done,
    output logic               div_zero
);

    localparam int CW = $clog2(WIDTH);

    state_t             state;
    state_t             next_state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   operand_q;
    logic               op_q;
    logic               neg_res;
    logic               neg_rem;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic               div0_launch;
    logic               busy_d;
    logic               done_d;
    logic               wr_d;
    logic [2*WIDTH-1:0] fix_prod;
    logic [WIDTH-1:0]   fix_lo;
    logic [WIDTH-1:0]   fix_hi;
    logic [2*WIDTH-1:0] fix_result;

    assign abs_a = a[WIDTH-1] ? -a : a;
    assign abs_b = b[WIDTH-1] ? -b : b;

`ifdef MULTDIV_DIV0_EN
    assign div0_launch = (op == OP_DIV) && (b == '0);
`else
    assign div0_launch = 1'b0;
`endif

    multdiv_step #(.WIDTH(WIDTH)) u_step (
        .op       (op_q),
        .acc      (acc),
        .operand  (operand_q),
        .acc_next (acc_step)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = div0_launch ? DONE : RUN;
            RUN:     if (cnt == '0) next_state = FIX;
            FIX:     next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are computed from next_state so they can be registered without extra latency.
    always_comb begin
        busy_d = (next_state != IDLE);
        done_d = (next_state == DONE);
        wr_d   = (next_state == DONE) && (state == FIX);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            result_wr <= 1'b0;
        end else begin
            busy      <= busy_d;
            done      <= done_d;
            result_wr <= wr_d;
        end
    end

`ifdef MULTDIV_DIV0_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) div_zero <= 1'b0;
        else        div_zero <= (state == IDLE) && (next_state == DONE);
    end
`else
    assign div_zero = 1'b0;
`endif

    // Remainder takes the dividend's sign so the quotient truncates toward zero.
    always_comb begin
        fix_prod   = neg_res ? -acc : acc;
        fix_lo     = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        fix_hi     = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        fix_result = (op_q == OP_MULT) ? fix_prod : {fix_hi, fix_lo};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            acc       <= '0;
            operand_q <= '0;
            op_q      <= 1'b0;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
            result    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q      <= op;
                        neg_res   <= a[WIDTH-1] ^ b[WIDTH-1];
                        neg_rem   <= a[WIDTH-1];
                        cnt       <= CW'(WIDTH - 1);
                        operand_q <= (op == OP_MULT) ? abs_a : abs_b;
                        acc       <= (op == OP_MULT) ? {{WIDTH{1'b0}}, abs_b}
                                                     : {{WIDTH{1'b0}}, abs_a};
                    end
                end
                RUN: begin
                    acc <= acc_step;
                    cnt <= cnt - CW'(1);
                end
                FIX:     result <= fix_result;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit; follows MULTDIV_DIV0_EN to pick zero-divisor expectations.
module tb_mult_div_unit;

    typedef struct {
        string       name;
        logic [63:0] res;
        logic        is_div0;
        int          exp_edge;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [63:0] result;
    logic        result_wr;
    logic        done;
    logic        div_zero;

    exp_t        exp_q[$];
    logic [63:0] exp_last;
    int          edge_count;
    int          check_count;
    int          error_count;

    mult_div_unit dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .result    (result),
        .result_wr (result_wr),
        .done      (done),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edge_count = 0;
    always @(posedge clk) edge_count <= edge_count + 1;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    function automatic logic [63:0] model(input logic m_op, input logic [31:0] m_a, input logic [31:0] m_b);
        longint sa;
        longint sd;
        longint q;
        longint r;
        longint p;
        sa = longint'($signed(m_a));
        sd = longint'($signed(m_b));
        if (m_op == 1'b0) begin
            p = sa * sd;
            return p;
        end
        q = sa / sd;
        r = sa % sd;
        return {r[31:0], q[31:0]};
    endfunction

    // Pops one expectation for every strobe the DUT emits.
    always @(negedge clk) begin
        if (reset && (done || result_wr || div_zero)) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_strobe", {61'd0, done, result_wr, div_zero}, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput({e.name, "_latency"}, 64'(edge_count), 64'(e.exp_edge));
                checkOutput({e.name, "_done"}, {63'd0, done}, 64'd1);
                checkOutput({e.name, "_result_wr"}, {63'd0, result_wr}, {63'd0, ~e.is_div0});
                checkOutput({e.name, "_div_zero"}, {63'd0, div_zero}, {63'd0, e.is_div0});
                checkOutput({e.name, "_result"}, result, e.res);
            end
        end
    end

    task automatic launchOp(input string name, input logic l_op, input logic [31:0] l_a,
                            input logic [31:0] l_b, input logic [63:0] exp_res, input logic is_div0);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        op    = l_op;
        a     = l_a;
        b     = l_b;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 1'($urandom);
        a     = $urandom;
        b     = $urandom;
        e.name     = name;
        e.is_div0  = is_div0;
        e.res      = is_div0 ? exp_last : exp_res;
        e.exp_edge = is_div0 ? edge_count : edge_count + 33;
        exp_q.push_back(e);
        if (!is_div0) exp_last = exp_res;
    endtask

    task automatic applyStimulus(input string name, input logic l_op, input logic [31:0] l_a,
                                 input logic [31:0] l_b, input logic [63:0] exp_res,
                                 input logic is_div0, input int restart_at);
        int busy_cycles;
        launchOp(name, l_op, l_a, l_b, exp_res, is_div0);
        busy_cycles = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (!busy) break;
            busy_cycles++;
            if (i == restart_at) begin
                start = 1'b1;
                op    = 1'b0;
                a     = 32'd3;
                b     = 32'd3;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        checkOutput({name, "_busy_cycles"}, 64'(busy_cycles), is_div0 ? 64'd1 : 64'd34);
        checkOutput({name, "_sb_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic        r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;
        check_count = 0;
        error_count = 0;
        exp_last    = 64'd0;
        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", {63'd0, busy}, 64'd0);
        checkOutput("rst_result", result, 64'd0);
        checkOutput("rst_result_wr", {63'd0, result_wr}, 64'd0);
        checkOutput("rst_done", {63'd0, done}, 64'd0);
        checkOutput("rst_div_zero", {63'd0, div_zero}, 64'd0);
        reset = 1'b1;

        applyStimulus("mult_7_m3", 1'b0, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 0);
        applyStimulus("mult_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 0);
        applyStimulus("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 0);
        applyStimulus("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1'b0, 0);
        applyStimulus("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, 10);
`ifdef MULTDIV_DIV0_EN
        applyStimulus("div_5_0", 1'b1, 32'd5, 32'd0, 64'd0, 1'b1, 0);
`else
        applyStimulus("div_5_0", 1'b1, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF, 1'b0, 0);
`endif

        for (int k = 0; k < 6; k++) begin
            r_op = 1'($urandom);
            r_a  = $urandom;
            r_b  = $urandom;
            if (k == 2) r_b = 32'hFFFF_FFF0 | (r_b & 32'h7);
            if (r_b == 32'd0) r_b = 32'd1;
            applyStimulus($sformatf("rand%0d", k), r_op, r_a, r_b, model(r_op, r_a, r_b), 1'b0, 0);
        end

        launchOp("abort", 1'b0, 32'd12345, 32'd678, 64'd8369910, 1'b0);
        repeat (11) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("abort_busy", {63'd0, busy}, 64'd0);
        checkOutput("abort_result", result, 64'd0);
        checkOutput("abort_result_wr", {63'd0, result_wr}, 64'd0);
        checkOutput("abort_done", {63'd0, done}, 64'd0);
        checkOutput("abort_div_zero", {63'd0, div_zero}, 64'd0);
        exp_q.delete();
        exp_last = 64'd0;
        @(negedge clk);
        reset = 1'b1;
        applyStimulus("mult_3x4", 1'b0, 32'd3, 32'd4, 64'h0000_0000_0000_000C, 1'b0, 0);

        repeat (3) @(negedge clk);
        checkOutput("final_sb_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
